// File: rtl/alu_cmd_driver_pkg.sv
// Shared types and constants for the ALU command driver: FSM states, opcodes,
// flag bit positions and the packed command word stored in the FIFO.
package alu_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_NAND = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_LAST = 4'hB;

    localparam int FLG_ZERO = 0;
    localparam int FLG_OVF  = 1;
    localparam int FLG_MOVF = 2;
    localparam int FLG_UNF  = 3;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       use_acc;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Bundles the command stream, the ALU operand/result bus and the response stream.
interface alu_cmd_driver_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_use_acc;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic [3:0] alu_flag;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [3:0] rsp_flag;
    logic       rsp_err;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        input  alu_out, alu_flag, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel,
        output rsp_valid, rsp_result, rsp_flag, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        output alu_out, alu_flag, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel,
        input  rsp_valid, rsp_result, rsp_flag, rsp_err
    );

endinterface

// File: rtl/alu_cmd_driver_fifo.sv
// Synchronous FIFO for queued ALU commands; power-of-two depth so pointers
// wrap naturally.
module cmd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 21,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage needs no reset; the cleared count marks every entry invalid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Sequential initiator for the 8-bit ALU: queues commands, drives registered
// operands, waits SETTLE cycles, then holds the captured result as a response.
module alu_cmd_driver
    import alu_drv_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_driver_if.master bus,
    output logic             busy
);

    localparam int               AW        = $clog2(DEPTH);
    localparam int               CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       acc_q, acc_d;
    logic [7:0]       alu_a_q, alu_a_d;
    logic [7:0]       alu_b_q, alu_b_d;
    logic [3:0]       alu_sel_q, alu_sel_d;
    logic [7:0]       rsp_result_q, rsp_result_d;
    logic [3:0]       rsp_flag_q, rsp_flag_d;
    logic             rsp_err_q, rsp_err_d;

    cmd_t        cmd_in;
    cmd_t        head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;
    logic        push;
    logic        pop;

    assign cmd_in = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, use_acc: bus.cmd_use_acc};
    assign push   = bus.cmd_valid && !fifo_full;
    assign pop    = (state_q == IDLE) && !fifo_empty;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (cmd_in),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // NOTE: sequential state uses non-blocking assignment only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = op_legal(head.op) ? DRIVE : RESP;
            DRIVE:   if (cnt_q == '0) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every target gets a hold default first, so no latch can be inferred.
    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_result_d = rsp_result_q;
        rsp_flag_d   = rsp_flag_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    if (op_legal(head.op)) begin
                        alu_a_d   = head.use_acc ? acc_q : head.a;
                        alu_b_d   = head.b;
                        alu_sel_d = head.op;
                        cnt_d     = SETTLE_LD;
                    end else begin
                        rsp_result_d = 8'h00;
                        rsp_flag_d   = 4'h0;
                        rsp_err_d    = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    rsp_result_d = bus.alu_out;
                    rsp_flag_d   = bus.alu_flag;
                    rsp_err_d    = 1'b0;
                    acc_d        = bus.alu_out;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            acc_q        <= 8'h00;
            alu_a_q      <= 8'h00;
            alu_b_q      <= 8'h00;
            alu_sel_q    <= 4'h0;
            rsp_result_q <= 8'h00;
            rsp_flag_q   <= 4'h0;
            rsp_err_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_result_q <= rsp_result_d;
            rsp_flag_q   <= rsp_flag_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.cmd_ready  = !fifo_full;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flag   = rsp_flag_q;
    assign bus.rsp_err    = rsp_err_q;
    assign busy           = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Sequential initiator for the 8-bit combinational ALU. It accepts ALU commands over a valid/ready stream and buffers them in a small FIFO. It drives the ALU operand/select inputs from registers, waits a programmable settle time, then captures the ALU result and flags into a held valid/ready response. An 8-bit accumulator lets a command reuse the previous result as operand A, so the block can chain operations without software round-trips.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- SETTLE, 1: cycles the ALU inputs are held before capture; ≥1.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full.
- cmd_op  in  4  ALU select, 0x0–0xB legal.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_use_acc  in  1  use accumulator instead of cmd_a.
- alu_a  out  8  registered ALU operand A.
- alu_b  out  8  registered ALU operand B.
- alu_sel  out  4  registered ALU select.
- alu_out  in  8  ALU result.
- alu_flag  in  4  ALU flags: bit0 zero, bit1 add/shift overflow, bit2 mul overflow, bit3 underflow.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_result  out  8  captured result.
- rsp_flag  out  4  captured flags.
- rsp_err  out  1  illegal opcode.
- busy  out  1  state ≠ IDLE or FIFO non-empty.

## Operation
- Command push: on cmd_valid && cmd_ready at a clk edge. cmd_ready = (count < DEPTH), from registered count only. There is no same-cycle pass-through of pop into ready.
- FSM states: IDLE, DRIVE, RESP.
- IDLE with FIFO non-empty: pop the head entry.
  - Legal op: load alu_a (acc if use_acc, else cmd_a), alu_b, and alu_sel; load the settle counter with SETTLE-1; go to DRIVE.
  - Illegal op (0xC–0xF): alu_* are unchanged; load rsp_result=0x00, rsp_flag=0x0, rsp_err=1; go to RESP. acc is unchanged.
- DRIVE: decrement the counter each cycle. When the counter is 0, sample alu_out and alu_flag into rsp_result and rsp_flag, set rsp_err=0, load acc ← alu_out, and go to RESP.
- RESP: rsp_valid=1. All rsp_* fields are stable until a handshake (rsp_valid && rsp_ready). On handshake, go to IDLE; the next pop happens in the following cycle.
- alu_* outputs hold their last value outside DRIVE.
- use_acc: acc is always current at pop time, because only one command is in flight. There is no hazard logic.
- Widths: all paths are 8-bit. acc takes exactly the 8-bit alu_out, with no extension.
- Reset values: cmd_ready=1, alu_a=0x00, alu_b=0x00, alu_sel=0x0, rsp_valid=0, rsp_result=0x00, rsp_flag=0x0, rsp_err=0, busy=0, acc=0x00, FIFO empty, state IDLE.
- Reset mid-operation: the FIFO contents, in-flight command, and pending response are discarded immediately. No response is emitted for them.

## Timing
- Legal op, accepted at edge N into an empty FIFO in IDLE:
  - Popped at edge N+1; alu_* valid from N+1.
  - Captured at edge N+1+SETTLE; rsp_valid high from then.
  - Latency is SETTLE+1 cycles.
- Illegal op: rsp_valid high from edge N+1.
- Back-to-back throughput: one command per SETTLE+2 cycles with rsp_ready tied high (pop, SETTLE cycles in DRIVE, 1 cycle in RESP).
- Full FIFO plus one in-service command: DEPTH+1 commands are accepted before cmd_ready falls.
- Push and pop on the same edge: count is unchanged.
- Pointer wrap is modulo DEPTH.

## Structure
- Package alu_drv_pkg:
  - state enum (IDLE, DRIVE, RESP);
  - opcode constants OP_ADD=0x0 … OP_NOR=0xB, OP_LAST=0xB;
  - flag bit indices FLG_ZERO=0, FLG_OVF=1, FLG_MOVF=2, FLG_UNF=3;
  - command struct {op, a, b, use_acc} (21 bits).
- Sub-module cmd_fifo: parameterized synchronous FIFO (DEPTH, width 21) with full, empty, and count outputs, using the same clk/rst.
- The FSM, settle counter, accumulator, and response registers live in the top level.

## Test plan
- ADD: a=0x12, b=0x34, SETTLE=1, rsp_ready=1 → alu_sel=0x0; rsp_result=0x46, rsp_err=0; rsp_valid exactly 2 cycles after the accept edge.
- Chain:
  - SUB 0x50,0x10 → rsp_result=0x40.
  - Then MUL, use_acc=1, b=0x02 → alu_a=0x40; rsp_result=0x80; acc=0x80.
- Illegal op 0xD with a=0xFF → rsp_valid after 1 cycle; rsp_result=0x00, rsp_err=1; alu_sel and acc unchanged.
- Backpressure, DEPTH=4:
  - Hold rsp_ready=0 and push continuously → exactly 5 commands accepted, then cmd_ready=0.
  - First response held stable throughout.
  - Release rsp_ready → 5 responses in order; cmd_ready rises one cycle after the first pop.
- Reset mid-DRIVE: pulse rst asynchronously → all outputs at reset values with no clock edge; busy=0; next command with use_acc=1 drives alu_a=0x00.
- SETTLE=3: ADD 0x01,0x02 → capture 4 cycles after accept; rsp_result=0x03.
